// File: rtl/fetch_pipe_ctrl.sv
// Fetch-stage sequencing controller: arbitrates redirect, halt, imem wait and load-use stalls.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_pipe_ctrl #(
  parameter int XLEN            = 32,
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc4_if_i,
  input  logic            br_taken_ex_i,
  input  logic [XLEN-1:0] br_target_ex_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic [1:0]      id_rs_used_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            ex_memread_i,
  input  logic            imem_ready_i,
  input  logic            halt_req_i,
  output logic [XLEN-1:0] npc_o,
  output logic            keep_o,
  output logic            back_o,
  output logic            stall_ifid_o,
  output logic            flush_ifid_o,
  output logic            flush_idex_o,
  output logic            halted_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LU_STALL   = 2'd1,
    ST_REDIR_WAIT = 2'd2,
    ST_HALT       = 2'd3
  } state_t;

  localparam logic [2:0] LU_LOAD = 3'(LU_STALL_CYCLES - 1);

  if (LU_STALL_CYCLES < 1 || LU_STALL_CYCLES > 7 || CNT_W < 1) begin : g_param_chk
    $error("fetch_pipe_ctrl: LU_STALL_CYCLES must be 1..7 and CNT_W at least 1");
  end

  state_t            state_r, state_nxt_s;
  logic [XLEN-1:0]   pend_r, pend_nxt_s;
  logic [2:0]        cnt_r, cnt_nxt_s;
  logic              lu_s;
  logic [XLEN-1:0]   npc_s;
  logic              keep_s, back_s, stall_s, fifl_s, fidx_s, halted_s;

  // Load-use hazard between the load in EX and the sources read in ID.
  always_comb begin
    lu_s = ex_memread_i & (ex_rd_i != 5'd0) &
           ((id_rs_used_i[0] & (id_rs1_i == ex_rd_i)) |
            (id_rs_used_i[1] & (id_rs2_i == ex_rd_i)));
  end

  // State, pending redirect target and bubble counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_RUN;
      pend_r  <= {XLEN{1'b0}};
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      pend_r  <= pend_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; a redirect always wins and clears any bubble count.
  always_comb begin
    state_nxt_s = state_r;
    pend_nxt_s  = pend_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_RUN, ST_LU_STALL: begin
        if (br_taken_ex_i) begin
          cnt_nxt_s = 3'd0;
          if (imem_ready_i) begin
            state_nxt_s = ST_RUN;
          end else begin
            pend_nxt_s  = br_target_ex_i;
            state_nxt_s = ST_REDIR_WAIT;
          end
        end else if (state_r == ST_LU_STALL) begin
          if (cnt_r <= 3'd1) begin
            cnt_nxt_s   = 3'd0;
            state_nxt_s = ST_RUN;
          end else begin
            cnt_nxt_s   = cnt_r - 3'd1;
            state_nxt_s = ST_LU_STALL;
          end
        end else if (halt_req_i) begin
          state_nxt_s = ST_HALT;
        end else if (!imem_ready_i) begin
          state_nxt_s = ST_RUN;
        end else if (lu_s) begin
          cnt_nxt_s   = LU_LOAD;
          state_nxt_s = (LU_LOAD != 3'd0) ? ST_LU_STALL : ST_RUN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_REDIR_WAIT: begin
        // Youngest redirect overwrites the pending target; halt waits for completion.
        if (br_taken_ex_i && !imem_ready_i) begin
          pend_nxt_s = br_target_ex_i;
        end else if (imem_ready_i) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_REDIR_WAIT;
        end
      end
      ST_HALT: begin
        if (!halt_req_i) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // Output decode; everything is forced to zero while reset is asserted.
  always_comb begin
    npc_s    = pc4_if_i;
    keep_s   = 1'b0;
    back_s   = 1'b0;
    stall_s  = 1'b0;
    fifl_s   = 1'b0;
    fidx_s   = 1'b0;
    halted_s = 1'b0;
    if (!rst_i) begin
      npc_s = {XLEN{1'b0}};
    end else begin
      case (state_r)
        ST_RUN, ST_LU_STALL: begin
          if (br_taken_ex_i && imem_ready_i) begin
            back_s = 1'b1;
            npc_s  = br_target_ex_i;
            fifl_s = 1'b1;
            fidx_s = 1'b1;
          end else if (br_taken_ex_i) begin
            keep_s = 1'b1;
            fifl_s = 1'b1;
            fidx_s = 1'b1;
          end else if (state_r == ST_LU_STALL) begin
            keep_s  = 1'b1;
            stall_s = 1'b1;
            fidx_s  = 1'b1;
          end else if (halt_req_i) begin
            keep_s  = 1'b1;
            stall_s = 1'b1;
            fidx_s  = 1'b1;
          end else if (!imem_ready_i) begin
            keep_s = 1'b1;
            fifl_s = 1'b1;
          end else if (lu_s) begin
            keep_s  = 1'b1;
            stall_s = 1'b1;
            fidx_s  = 1'b1;
          end else begin
            npc_s = pc4_if_i;
          end
        end
        ST_REDIR_WAIT: begin
          fifl_s = 1'b1;
          if (br_taken_ex_i && imem_ready_i) begin
            back_s = 1'b1;
            npc_s  = br_target_ex_i;
            fidx_s = 1'b1;
          end else if (br_taken_ex_i) begin
            keep_s = 1'b1;
            fidx_s = 1'b1;
          end else if (imem_ready_i) begin
            back_s = 1'b1;
            npc_s  = pend_r;
          end else begin
            keep_s = 1'b1;
          end
        end
        ST_HALT: begin
          keep_s   = 1'b1;
          stall_s  = 1'b1;
          halted_s = 1'b1;
        end
        default: begin
          keep_s = 1'b0;
        end
      endcase
    end
  end

  assign npc_o        = npc_s;
  assign keep_o       = keep_s;
  assign back_o       = back_s;
  assign stall_ifid_o = stall_s;
  assign flush_ifid_o = fifl_s;
  assign flush_idex_o = fidx_s;
  assign halted_o     = halted_s;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // Stall and redirect event counters; both wrap naturally.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (keep_s && !halted_s) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (back_s) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_r;
  assign flush_cnt_o = flush_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Scoreboard bench for fetch_pipe_ctrl: expected outputs are queued as stimulus is driven
// and compared shortly before each active clock edge.
module tb_fetch_pipe_ctrl;

  localparam logic [5:0] F_RUN   = 6'b000000;
  localparam logic [5:0] F_LU    = 6'b101010;
  localparam logic [5:0] F_BRR   = 6'b010110;
  localparam logic [5:0] F_BRW   = 6'b100110;
  localparam logic [5:0] F_RW    = 6'b100100;
  localparam logic [5:0] F_RDONE = 6'b010100;
  localparam logic [5:0] F_HLT   = 6'b101001;

  typedef struct {
    string       tag;
    logic [31:0] npc;
    logic [5:0]  flags;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  logic        clk_s = 1'b0;
  logic        rst_s, br_s, memread_s, ready_s, halt_s;
  logic [31:0] pc4_s, tgt_s, npc_s;
  logic [4:0]  rs1_s, rs2_s, rd_s;
  logic [1:0]  used_s;
  logic        keep_s, back_s, stall_s, fifl_s, fidx_s, halted_s;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_s, flush_cnt_s;
`endif

  exp_t        sb_q[$];
  int          checks_r = 0;
  int          failures_r = 0;
  logic [31:0] m_scnt_r = 32'd0;
  logic [31:0] m_fcnt_r = 32'd0;

  always #5 clk_s = ~clk_s;

  fetch_pipe_ctrl #(.XLEN(32), .LU_STALL_CYCLES(2), .CNT_W(32)) dut (
    .clk_i(clk_s), .rst_i(rst_s), .pc4_if_i(pc4_s),
    .br_taken_ex_i(br_s), .br_target_ex_i(tgt_s),
    .id_rs1_i(rs1_s), .id_rs2_i(rs2_s), .id_rs_used_i(used_s),
    .ex_rd_i(rd_s), .ex_memread_i(memread_s),
    .imem_ready_i(ready_s), .halt_req_i(halt_s),
    .npc_o(npc_s), .keep_o(keep_s), .back_o(back_s),
    .stall_ifid_o(stall_s), .flush_ifid_o(fifl_s), .flush_idex_o(fidx_s),
    .halted_o(halted_s)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_s), .flush_cnt_o(flush_cnt_s)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_r++;
    if (obs !== exp) begin
      failures_r++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the expected outputs.
  task automatic cyc(input string tag, input logic rst, input logic [31:0] pc4,
                     input logic br, input logic [31:0] tgt, input logic [4:0] rd,
                     input logic mr, input logic rdy, input logic hlt,
                     input logic [5:0] eflags, input logic [31:0] enpc);
    exp_t e;
    @(negedge clk_s);
    rst_s = rst; pc4_s = pc4; br_s = br; tgt_s = tgt; rd_s = rd;
    memread_s = mr; ready_s = rdy; halt_s = hlt;
    if (!rst) begin
      m_scnt_r = 32'd0;
      m_fcnt_r = 32'd0;
    end
    e.tag = tag; e.npc = enpc; e.flags = eflags; e.scnt = m_scnt_r; e.fcnt = m_fcnt_r;
    sb_q.push_back(e);
    if (rst) begin
      m_scnt_r = m_scnt_r + {31'd0, eflags[5] & ~eflags[0]};
      m_fcnt_r = m_fcnt_r + {31'd0, eflags[4]};
    end
  endtask

  // Pop and compare a queued expectation well before the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_s);
      #4;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.tag, "/npc"}, {32'd0, npc_s}, {32'd0, e.npc});
        chk({e.tag, "/ctl"}, {58'd0, keep_s, back_s, stall_s, fifl_s, fidx_s, halted_s},
            {58'd0, e.flags});
`ifdef FETCH_PERF_CNT_EN
        chk({e.tag, "/scnt"}, {32'd0, stall_cnt_s}, {32'd0, e.scnt});
        chk({e.tag, "/fcnt"}, {32'd0, flush_cnt_s}, {32'd0, e.fcnt});
`endif
      end
    end
  end

  initial begin
    rst_s = 1'b0; pc4_s = 32'h4; br_s = 1'b0; tgt_s = 32'h0; rd_s = 5'd0;
    memread_s = 1'b0; ready_s = 1'b1; halt_s = 1'b0;
    rs1_s = 5'd5; rs2_s = 5'd7; used_s = 2'b01;

    cyc("reset",      1'b0, 32'h4,   1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b0, F_RUN,   32'h0);
    cyc("run",        1'b1, 32'h4,   1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b0, F_RUN,   32'h4);
    cyc("lu1",        1'b1, 32'h8,   1'b0, 32'h0,   5'd5, 1'b1, 1'b1, 1'b0, F_LU,    32'h8);
    cyc("lu2",        1'b1, 32'h8,   1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b0, F_LU,    32'h8);
    cyc("lu_release", 1'b1, 32'h8,   1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b0, F_RUN,   32'h8);
    cyc("lu_rd0",     1'b1, 32'hc,   1'b0, 32'h0,   5'd0, 1'b1, 1'b1, 1'b0, F_RUN,   32'hc);
    cyc("br_lu",      1'b1, 32'h10,  1'b1, 32'h100, 5'd5, 1'b1, 1'b1, 1'b0, F_BRR,   32'h100);
    cyc("after_br",   1'b1, 32'h104, 1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b0, F_RUN,   32'h104);
    cyc("imem_wait",  1'b1, 32'h108, 1'b0, 32'h0,   5'd0, 1'b0, 1'b0, 1'b0, F_RW,    32'h108);
    cyc("brw1",       1'b1, 32'h108, 1'b1, 32'h200, 5'd0, 1'b0, 1'b0, 1'b0, F_BRW,   32'h108);
    cyc("brw2",       1'b1, 32'h108, 1'b0, 32'h0,   5'd0, 1'b0, 1'b0, 1'b0, F_RW,    32'h108);
    cyc("brw3",       1'b1, 32'h108, 1'b0, 32'h0,   5'd0, 1'b0, 1'b0, 1'b0, F_RW,    32'h108);
    cyc("brw_done",   1'b1, 32'h108, 1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b0, F_RDONE, 32'h200);
    cyc("brw_next",   1'b1, 32'h204, 1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b0, F_RUN,   32'h204);
    cyc("halt1",      1'b1, 32'h208, 1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b1, F_LU,    32'h208);
    cyc("halt2",      1'b1, 32'h208, 1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b1, F_HLT,   32'h208);
    cyc("halt3",      1'b1, 32'h208, 1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b1, F_HLT,   32'h208);
    cyc("halt4",      1'b1, 32'h208, 1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b1, F_HLT,   32'h208);
    cyc("halt_rel",   1'b1, 32'h208, 1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b0, F_HLT,   32'h208);
    cyc("halt_run",   1'b1, 32'h208, 1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b0, F_RUN,   32'h208);
    cyc("yw_br1",     1'b1, 32'h20c, 1'b1, 32'h300, 5'd0, 1'b0, 1'b0, 1'b0, F_BRW,   32'h20c);
    cyc("yw_br2",     1'b1, 32'h20c, 1'b1, 32'h380, 5'd0, 1'b0, 1'b0, 1'b1, F_BRW,   32'h20c);
    cyc("yw_hold",    1'b1, 32'h20c, 1'b0, 32'h0,   5'd0, 1'b0, 1'b0, 1'b1, F_RW,    32'h20c);
    cyc("yw_done",    1'b1, 32'h20c, 1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b1, F_RDONE, 32'h380);
    cyc("dfr_halt",   1'b1, 32'h384, 1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b1, F_LU,    32'h384);
    cyc("dfr_hlt2",   1'b1, 32'h384, 1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b0, F_HLT,   32'h384);
    cyc("dfr_run",    1'b1, 32'h384, 1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b0, F_RUN,   32'h384);
    cyc("rst_br",     1'b1, 32'h400, 1'b1, 32'h500, 5'd0, 1'b0, 1'b0, 1'b0, F_BRW,   32'h400);
    cyc("rst_mid",    1'b0, 32'h400, 1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b0, F_RUN,   32'h0);
    cyc("rst_after",  1'b1, 32'h404, 1'b0, 32'h0,   5'd0, 1'b0, 1'b1, 1'b0, F_RUN,   32'h404);
    cyc("rst_after2", 1'b1, 32'h408, 1'b0, 32'h0,   5'd5, 1'b1, 1'b1, 1'b0, F_LU,    32'h408);

    @(negedge clk_s);
    #6;
    chk("sb_drain", {32'd0, 32'(sb_q.size())}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
